// File: rtl/default_block_dma_packetizer.sv
// Frames the 64-bit sample/tag stream into DMA packets: m_last after cfg_packet_len words
// or on any tag word, through a registered output stage with a one-entry skid buffer.
module default_block_dma_packetizer #(
  parameter int DWIDTH    = 64,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [LEN_WIDTH-1:0] cfg_packet_len,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DWIDTH-1:0]    s_data,
  input  logic                 s_tag_valid,
  input  logic [6:0]           s_tag_type,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 m_tag_valid,
  output logic [6:0]           m_tag_type,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] stat_packets,
  output logic [CNT_WIDTH-1:0] stat_tags,
  output logic                 busy
);

  // Handshake: a word moves on a side only in a cycle where that side's valid and ready
  // are both high; once m_valid rises, m_valid and all m_* fields hold until m_ready.

  logic                 s_ready_q;
  logic                 m_valid_q;
  logic [DWIDTH-1:0]    m_data_q;
  logic                 m_tag_q;
  logic [6:0]           m_type_q;
  logic                 m_last_q;

  logic                 skid_full_q;
  logic                 skid_full_d;
  logic [DWIDTH-1:0]    skid_data_q;
  logic                 skid_tag_q;
  logic [6:0]           skid_type_q;
  logic                 skid_last_q;

  logic [LEN_WIDTH-1:0] word_cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] stat_pkt_q;
  logic [CNT_WIDTH-1:0] stat_tag_q;

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 out_free;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [LEN_WIDTH-1:0] cur_len;
  logic                 last_in;

  always_comb begin
    in_xfer  = s_valid & s_ready_q;
    out_xfer = m_valid_q & m_ready;
    out_free = ~m_valid_q | m_ready;
    len_eff  = (cfg_packet_len == '0) ? LEN_WIDTH'(1) : cfg_packet_len;
    // The first word of a packet sees the live length; later words use the latched one.
    cur_len  = (word_cnt_q == '0) ? len_eff : len_q;
    last_in  = cfg_enable & (s_tag_valid | (word_cnt_q == cur_len - LEN_WIDTH'(1)));
    // s_ready is held low while the skid is full, so input and skid drain never coincide.
    if (out_free) skid_full_d = 1'b0;
    else          skid_full_d = skid_full_q | in_xfer;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_tag_q     <= 1'b0;
      m_type_q    <= '0;
      m_last_q    <= 1'b0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= 1'b0;
      skid_type_q <= '0;
      skid_last_q <= 1'b0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      stat_pkt_q  <= '0;
      stat_tag_q  <= '0;
    end else begin
      s_ready_q   <= ~skid_full_d;
      skid_full_q <= skid_full_d;

      if (out_free) begin
        if (skid_full_q) begin
          m_valid_q <= 1'b1;
          m_data_q  <= skid_data_q;
          m_tag_q   <= skid_tag_q;
          m_type_q  <= skid_type_q;
          m_last_q  <= skid_last_q;
        end else if (in_xfer) begin
          m_valid_q <= 1'b1;
          m_data_q  <= s_data;
          m_tag_q   <= s_tag_valid;
          m_type_q  <= s_tag_type;
          m_last_q  <= last_in;
        end else begin
          m_valid_q <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_data_q <= s_data;
        skid_tag_q  <= s_tag_valid;
        skid_type_q <= s_tag_type;
        skid_last_q <= last_in;
      end

      // Dropping enable abandons any partial packet.
      if (!cfg_enable) begin
        word_cnt_q <= '0;
      end else if (in_xfer) begin
        if (word_cnt_q == '0) len_q <= len_eff;
        word_cnt_q <= last_in ? '0 : word_cnt_q + LEN_WIDTH'(1);
      end

      if (out_xfer && cfg_enable) begin
        if (m_last_q) stat_pkt_q <= stat_pkt_q + CNT_WIDTH'(1);
        if (m_tag_q)  stat_tag_q <= stat_tag_q + CNT_WIDTH'(1);
      end
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_tag_valid  = m_tag_q;
  assign m_tag_type   = m_type_q;
  assign m_last       = m_last_q;
  assign stat_packets = stat_pkt_q;
  assign stat_tags    = stat_tag_q;
  assign busy         = (word_cnt_q != '0);

endmodule

// File: tb/tb_default_block_dma_packetizer.sv
// Directed bench for default_block_dma_packetizer: framing, tags, back-pressure,
// length boundaries, enable/reset behaviour and counter wrap (4-bit counters).
module tb_default_block_dma_packetizer;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_enable;
  logic [LW-1:0] cfg_packet_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_tag_valid;
  logic [6:0]    s_tag_type;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_tag_valid;
  logic [6:0]    m_tag_type;
  logic          m_last;
  logic [CW-1:0] stat_packets;
  logic [CW-1:0] stat_tags;
  logic          busy;

  logic          m_ready_man;
  logic          bp_en = 1'b0;
  logic          bp_r = 1'b1;
  int            bp_idx = 0;

  assign m_ready = bp_en ? bp_r : m_ready_man;

  default_block_dma_packetizer #(.DWIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_packet_len(cfg_packet_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag_valid(s_tag_valid),
    .s_tag_type(s_tag_type), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_tag_valid(m_tag_valid), .m_tag_type(m_tag_type), .m_last(m_last),
    .stat_packets(stat_packets), .stat_tags(stat_tags), .busy(busy)
  );

  always #5 clk = ~clk;

  // m_ready pattern 1,0,0,1 repeating
  always @(negedge clk) begin
    if (bp_en) begin
      bp_r = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
      bp_idx++;
    end
  end

  // Monitor: record accepted output words and the before/after view of stalled cycles.
  logic [79:0] got_q[$];
  logic [79:0] stall_prev_q[$];
  logic [79:0] stall_cur_q[$];
  logic        prev_stall = 1'b0;
  logic [79:0] prev_rec;
  logic [79:0] cur_rec;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      cur_rec = {6'd0, m_valid, m_last, m_tag_valid, m_tag_type, m_data};
      if (prev_stall) begin
        stall_prev_q.push_back(prev_rec);
        stall_cur_q.push_back(cur_rec);
      end
      if (m_valid && m_ready) got_q.push_back(cur_rec);
      prev_stall = m_valid && !m_ready;
      prev_rec   = cur_rec;
    end
  end

  int          n_assert = 0;
  int          n_fail = 0;
  int          got_rd = 0;
  int          stall_rd = 0;
  logic [79:0] exp_q[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int t, input int i);
    return (64'(t) << 32) | 64'(i);
  endfunction

  task automatic send(input logic [63:0] d, input logic tg, input logic [6:0] ty);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_tag_valid = tg; s_tag_type = ty;
    for (int c = 0; c < 40 && !acc; c++) begin
      acc = s_ready;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("send_accept", 80'(acc), 80'(1));
  endtask

  task automatic send_exp(input logic [63:0] d, input logic tg, input logic [6:0] ty,
                          input logic last);
    exp_q.push_back({6'd0, 1'b1, last, tg, ty, d});
    send(d, tg, ty);
  endtask

  task automatic check_stream(input string t);
    for (int c = 0; c < 80 && (got_q.size() - got_rd) < exp_q.size(); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({t, "_count"}, 80'(got_q.size() - got_rd), 80'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (got_rd + k < got_q.size())
        chk($sformatf("%s_w%0d", t, k), got_q[got_rd + k], exp_q[k]);
    end
    got_rd = got_q.size();
    exp_q.delete();
    while (stall_rd < stall_cur_q.size()) begin
      chk({t, "_stall_hold"}, stall_cur_q[stall_rd], stall_prev_q[stall_rd]);
      stall_rd++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    got_rd = got_q.size();
    stall_rd = stall_cur_q.size();
    exp_q.delete();
    chk("rst_s_ready_low", 80'(s_ready), 80'(0));
    chk("rst_m_valid", 80'(m_valid), 80'(0));
    chk("rst_m_fields", 80'({m_last, m_tag_valid, m_tag_type, m_data}), 80'(0));
    chk("rst_packets", 80'(stat_packets), 80'(0));
    chk("rst_tags", 80'(stat_tags), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    @(negedge clk);
    chk("rst_s_ready_high", 80'(s_ready), 80'(1));
  endtask

  initial begin
    reset = 1'b1; cfg_enable = 1'b1; cfg_packet_len = 16'd4;
    s_valid = 1'b0; s_data = '0; s_tag_valid = 1'b0; s_tag_type = '0; m_ready_man = 1'b1;

    // Length framing: len=4, 10 words, last on 3 and 7
    do_reset();
    chk("t1_idle_valid", 80'(m_valid), 80'(0));
    send_exp(dat(1, 0), 1'b0, 7'd0, 1'b0);
    chk("t1_latency_valid", 80'(m_valid), 80'(1));
    chk("t1_latency_data", 80'(m_data), 80'(dat(1, 0)));
    for (int i = 1; i < 10; i++) send_exp(dat(1, i), 1'b0, 7'd0, (i == 3) || (i == 7));
    check_stream("t1");
    chk("t1_packets", 80'(stat_packets), 80'(2));
    chk("t1_tags", 80'(stat_tags), 80'(0));
    chk("t1_busy", 80'(busy), 80'(1));

    // Tag terminates a packet: len=8, tag at word 3, last on 3 and 11
    do_reset();
    cfg_packet_len = 16'd8;
    for (int i = 0; i < 12; i++)
      send_exp(dat(2, i), i == 3, (i == 3) ? 7'h01 : 7'h00, (i == 3) || (i == 11));
    check_stream("t2");
    chk("t2_packets", 80'(stat_packets), 80'(2));
    chk("t2_tags", 80'(stat_tags), 80'(1));
    chk("t2_busy", 80'(busy), 80'(0));

    // Back-pressure: fill output + skid, then 1,0,0,1 m_ready with random gaps
    do_reset();
    cfg_packet_len = 16'd4;
    m_ready_man = 1'b0;
    send_exp(dat(3, 0), 1'b0, 7'd0, 1'b0);
    send_exp(dat(3, 1), 1'b0, 7'd0, 1'b0);
    chk("t3_s_ready_drop", 80'(s_ready), 80'(0));
    chk("t3_stall_valid", 80'(m_valid), 80'(1));
    chk("t3_stall_data", 80'(m_data), 80'(dat(3, 0)));
    m_ready_man = 1'b1;
    @(negedge clk);
    chk("t3_skid_drain_data", 80'(m_data), 80'(dat(3, 1)));
    chk("t3_s_ready_back", 80'(s_ready), 80'(1));
    bp_idx = 0;
    bp_en = 1'b1;
    for (int i = 2; i < 14; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_exp(dat(3, i), 1'b0, 7'd0, (i == 3) || (i == 7) || (i == 11));
    end
    check_stream("t3");
    bp_en = 1'b0;
    chk("t3_packets", 80'(stat_packets), 80'(3));
    chk("t3_busy", 80'(busy), 80'(1));

    // Boundaries: len=0, len=1 with tag, len 4->2 mid-packet
    do_reset();
    cfg_packet_len = 16'd0;
    for (int i = 0; i < 3; i++) send_exp(dat(4, i), 1'b0, 7'd0, 1'b1);
    cfg_packet_len = 16'd1;
    send_exp(dat(4, 3), 1'b1, 7'h22, 1'b1);
    cfg_packet_len = 16'd4;
    send_exp(dat(4, 4), 1'b0, 7'd0, 1'b0);
    send_exp(dat(4, 5), 1'b0, 7'd0, 1'b0);
    cfg_packet_len = 16'd2;
    send_exp(dat(4, 6), 1'b0, 7'd0, 1'b0);
    send_exp(dat(4, 7), 1'b0, 7'd0, 1'b1);
    send_exp(dat(4, 8), 1'b0, 7'd0, 1'b0);
    send_exp(dat(4, 9), 1'b0, 7'd0, 1'b1);
    check_stream("t4");
    chk("t4_packets", 80'(stat_packets), 80'(6));
    chk("t4_tags", 80'(stat_tags), 80'(1));
    chk("t4_busy", 80'(busy), 80'(0));

    // Enable: disabled words carry no last and leave counters alone
    do_reset();
    cfg_enable = 1'b0;
    cfg_packet_len = 16'd4;
    for (int i = 0; i < 5; i++) send_exp(dat(5, i), i == 2, (i == 2) ? 7'h05 : 7'h00, 1'b0);
    check_stream("t5a");
    chk("t5_dis_packets", 80'(stat_packets), 80'(0));
    chk("t5_dis_tags", 80'(stat_tags), 80'(0));
    chk("t5_dis_busy", 80'(busy), 80'(0));
    cfg_enable = 1'b1;
    send_exp(dat(5, 5), 1'b0, 7'd0, 1'b0);
    send_exp(dat(5, 6), 1'b0, 7'd0, 1'b0);
    chk("t5_partial_busy", 80'(busy), 80'(1));
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("t5_abandon_busy", 80'(busy), 80'(0));
    cfg_enable = 1'b1;
    for (int i = 7; i < 11; i++) send_exp(dat(5, i), 1'b0, 7'd0, i == 10);
    check_stream("t5b");
    chk("t5_packets", 80'(stat_packets), 80'(1));

    // Reset with two words buffered
    m_ready_man = 1'b0;
    send(dat(6, 0), 1'b0, 7'd0);
    send(dat(6, 1), 1'b0, 7'd0);
    chk("t6_buffered_valid", 80'(m_valid), 80'(1));
    chk("t6_buffered_s_ready", 80'(s_ready), 80'(0));
    reset = 1'b1;
    #1;
    chk("t6_async_m_valid", 80'(m_valid), 80'(0));
    chk("t6_async_s_ready", 80'(s_ready), 80'(0));
    chk("t6_async_packets", 80'(stat_packets), 80'(0));
    m_ready_man = 1'b1;
    do_reset();
    check_stream("t6");

    // Counter wrap: 4-bit counter, len=1, 17 words
    cfg_packet_len = 16'd1;
    for (int i = 0; i < 17; i++) send_exp(dat(7, i), 1'b0, 7'd0, 1'b1);
    check_stream("t7");
    chk("t7_packets_wrap", 80'(stat_packets), 80'(1));
    chk("t7_tags", 80'(stat_tags), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
